regfile_wb_arbiter: RTL and testbench

Write-side front end for the 32x32 register file. It merges in-order stage-3 writebacks with completions from a long-latency unit (multi-cycle mul/div, later loads) onto the register file's single write port (RegWEn / rd_addr / wdata). Late completions are buffered in a small FIFO. The block exposes per-operand busy flags for hazard stalls and provides anti-starvation back-pressure to the pipeline.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_wb_fifo.sv | 86 ++++++++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core definitions for the register-file write side: widths, the x0 address
// and the writeback request record used by stage 3 and the register file.
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// In-order buffer for long-latency completions, with a per-entry valid/rd view
// so the top level can detect pending writes to decode-stage source registers.
module wb_fifo
    import regfile_wb_arbiter_pkg::REG_ADDR_W;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [REG_ADDR_W-1:0]       push_rd_i,
    input  logic [DW-1:0]               push_data_i,
    input  logic                        pop_i,
    output logic [REG_ADDR_W-1:0]       head_rd_o,
    output logic [DW-1:0]               head_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic [DEPTH-1:0]            ent_valid_o,
    output logic [DEPTH*REG_ADDR_W-1:0] ent_rd_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DW-1:0]         data_mem [DEPTH];
    logic                  push_eff, pop_eff;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign push_eff = push_i && !full_o;
    assign pop_eff  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        if (pop_eff) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PW'(1);
        end
        if (push_eff) begin
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: valid_q gates every consumer.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            rd_mem[wptr_q]   <= push_rd_i;
            data_mem[wptr_q] <= push_data_i;
        end
    end

    assign head_rd_o   = rd_mem[rptr_q];
    assign head_data_o = data_mem[rptr_q];
    assign count_o     = count_q;
    assign ent_valid_o = valid_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_rd_o[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem[i];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges stage-3 writebacks and buffered long-latency completions onto the single
// register-file write port, with busy flags and anti-starvation stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::REG_ADDR_W, regfile_wb_arbiter_pkg::REG_ZERO;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = regfile_wb_arbiter_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_wen,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wdata,
    output logic                  pipe_stall,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_wdata,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  RegWEn,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       wdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                        fifo_push, fifo_pop;
    logic [REG_ADDR_W-1:0]       head_rd;
    logic [XLEN-1:0]             head_data;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]      fifo_count;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] ent_rd;

    logic                  regwen_q, regwen_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  pipe_req, starved;
    logic                  rs1_hit, rs2_hit;

    assign lu_ready  = !fifo_full;
    // Writes to x0 complete the handshake but are never stored.
    assign fifo_push = lu_valid && lu_ready && (lu_rd != REG_ZERO);
    assign pipe_req  = pipe_wen && (pipe_rd != REG_ZERO);
    assign starved   = !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));

    wb_fifo #(.DEPTH(DEPTH), .DW(XLEN)) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (fifo_push),
        .push_rd_i   (lu_rd),
        .push_data_i (lu_wdata),
        .pop_i       (fifo_pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    always_comb begin
        regwen_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        wdata_d    = wdata_q;
        fifo_pop   = 1'b0;
        pipe_stall = 1'b0;
        starve_d   = starve_q;
        if (starved) begin
            fifo_pop   = 1'b1;
            pipe_stall = pipe_req;
            regwen_d   = 1'b1;
            rd_addr_d  = head_rd;
            wdata_d    = head_data;
        end else if (pipe_req) begin
            regwen_d  = 1'b1;
            rd_addr_d = pipe_rd;
            wdata_d   = pipe_wdata;
            if (!fifo_empty && (starve_q < SW'(STARVE_LIMIT))) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            regwen_d  = 1'b1;
            rd_addr_d = head_rd;
            wdata_d   = head_data;
        end
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwen_q  <= 1'b0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
        end else begin
            regwen_q  <= regwen_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs1_addr)) rs1_hit = 1'b1;
            if (ent_valid[i] && (ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs2_addr)) rs2_hit = 1'b1;
        end
        if (regwen_q && (rd_addr_q == rs1_addr)) rs1_hit = 1'b1;
        if (regwen_q && (rd_addr_q == rs2_addr)) rs2_hit = 1'b1;
    end

    assign rs1_busy = (rs1_addr != REG_ZERO) && rs1_hit;
    assign rs2_busy = (rs2_addr != REG_ZERO) && rs2_hit;

    assign RegWEn  = regwen_q;
    assign rd_addr = rd_addr_q;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for arbitration, busy and
// starvation, plus sequences for FIFO wrap ordering and mid-stream reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        RegWEn;
  logic [4:0]  rd_addr;
  logic [31:0] wdata;

  int checks;
  int errors;

  logic [36:0] exp_q[$];

  typedef struct {
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pwd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_stall;
    logic        e_ready;
    logic        e_b1;
    logic        e_b2;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vt[23];

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_wen   (pipe_wen),
    .pipe_rd    (pipe_rd),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .RegWEn     (RegWEn),
    .rd_addr    (rd_addr),
    .wdata      (wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic pw, logic [4:0] prd, logic [31:0] pwd,
                              logic lv, logic [4:0] lrd, logic [31:0] lwd,
                              logic [4:0] r1, logic [4:0] r2,
                              logic es, logic er, logic eb1, logic eb2,
                              logic ew, logic [4:0] erd, logic [31:0] ewd);
    vec_t v;
    v.pw = pw; v.prd = prd; v.pwd = pwd;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd;
    v.r1 = r1; v.r2 = r2;
    v.e_stall = es; v.e_ready = er; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_wen = ew; v.e_rd = erd; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    pipe_wen = 1'b0; pipe_rd = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_wdata = '0;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vt[idx];
    @(negedge clk);
    pipe_wen = v.pw; pipe_rd = v.prd; pipe_wdata = v.pwd;
    lu_valid = v.lv; lu_rd = v.lrd; lu_wdata = v.lwd;
    rs1_addr = v.r1; rs2_addr = v.r2;
    #1;
    check($sformatf("v%0d_pipe_stall", idx), 64'(pipe_stall), 64'(v.e_stall));
    check($sformatf("v%0d_lu_ready", idx), 64'(lu_ready), 64'(v.e_ready));
    check($sformatf("v%0d_rs1_busy", idx), 64'(rs1_busy), 64'(v.e_b1));
    check($sformatf("v%0d_rs2_busy", idx), 64'(rs2_busy), 64'(v.e_b2));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_RegWEn", idx), 64'(RegWEn), 64'(v.e_wen));
    check($sformatf("v%0d_rd_addr", idx), 64'(rd_addr), 64'(v.e_rd));
    check($sformatf("v%0d_wdata", idx), 64'(wdata), 64'(v.e_wd));
  endtask

  // scoreboard: compare each register-file write against the expected queue
  task automatic monitor_write();
    logic [36:0] e;
    if (RegWEn) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_spurious_write: got rd=%0d data=0x%0h expected no write", rd_addr, wdata);
      end else begin
        e = exp_q.pop_front();
        check("wrap_order", {27'd0, rd_addr, wdata}, {27'd0, e});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    drive_idle();

    vt[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 1, 0, 0, 0, 0,  32'h0);
    vt[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,      5, 0, 0, 1, 0, 0, 1, 5,  32'hDEADBEEF);
    vt[2]  = mk(1, 0, 32'h11111111, 0, 0, 32'h0,      5, 0, 0, 1, 1, 0, 0, 5,  32'hDEADBEEF);
    vt[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      5, 0, 0, 1, 0, 0, 0, 5,  32'hDEADBEEF);
    vt[4]  = mk(0, 0, 32'h0,        1, 7, 32'h1234,   7, 0, 0, 1, 0, 0, 0, 5,  32'hDEADBEEF);
    vt[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 0, 0, 1, 1, 0, 1, 7,  32'h1234);
    vt[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 0, 0, 1, 1, 0, 0, 7,  32'h1234);
    vt[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      7, 0, 0, 1, 0, 0, 0, 7,  32'h1234);
    vt[8]  = mk(0, 0, 32'h0,        1, 0, 32'hFFFF,   0, 0, 0, 1, 0, 0, 0, 7,  32'h1234);
    vt[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 7, 0, 1, 0, 0, 0, 7,  32'h1234);
    vt[10] = mk(1, 10, 32'hA0,      1, 3, 32'h33,     3, 4, 0, 1, 0, 0, 1, 10, 32'hA0);
    vt[11] = mk(1, 11, 32'hA1,      1, 4, 32'h44,     3, 4, 0, 1, 1, 0, 1, 11, 32'hA1);
    vt[12] = mk(1, 12, 32'hA2,      1, 9, 32'h99,     3, 4, 0, 0, 1, 1, 1, 12, 32'hA2);
    vt[13] = mk(1, 13, 32'hA3,      0, 0, 32'h0,      3, 4, 0, 0, 1, 1, 1, 13, 32'hA3);
    vt[14] = mk(1, 14, 32'hA4,      0, 0, 32'h0,      3, 4, 0, 0, 1, 1, 1, 14, 32'hA4);
    vt[15] = mk(1, 14, 32'hA4,      0, 0, 32'h0,      3, 4, 1, 0, 1, 1, 1, 3,  32'h33);
    vt[16] = mk(1, 14, 32'hA4,      0, 0, 32'h0,      3, 4, 0, 1, 1, 1, 1, 14, 32'hA4);
    vt[17] = mk(1, 15, 32'hA5,      0, 0, 32'h0,      3, 4, 0, 1, 0, 1, 1, 15, 32'hA5);
    vt[18] = mk(1, 16, 32'hA6,      0, 0, 32'h0,      3, 4, 0, 1, 0, 1, 1, 16, 32'hA6);
    vt[19] = mk(1, 17, 32'hA7,      0, 0, 32'h0,      3, 4, 0, 1, 0, 1, 1, 17, 32'hA7);
    vt[20] = mk(1, 18, 32'hA8,      0, 0, 32'h0,      3, 4, 1, 1, 0, 1, 1, 4,  32'h44);
    vt[21] = mk(1, 18, 32'hA8,      0, 0, 32'h0,      3, 4, 0, 1, 0, 1, 1, 18, 32'hA8);
    vt[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,      3, 4, 0, 1, 0, 0, 0, 18, 32'hA8);

    // Reset values must appear before any clock edge.
    #1;
    check("rst_RegWEn", 64'(RegWEn), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_lu_ready", 64'(lu_ready), 64'd1);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply_vec(i);
    end

    // Ten back-to-back pushes with an idle pipe: push and pop coincide at count 1.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pipe_wen = 1'b0;
      lu_valid = 1'b1;
      lu_rd    = 5'(i + 1);
      lu_wdata = 32'hC000_0000 + 32'(i);
      #1;
      check($sformatf("wrap_lu_ready_%0d", i), 64'(lu_ready), 64'd1);
      exp_q.push_back({lu_rd, lu_wdata});
      @(posedge clk);
      #1;
      monitor_write();
    end
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
      monitor_write();
    end
    check("wrap_drain_left", 64'(exp_q.size()), 64'd0);

    // Fill the FIFO behind a busy pipe, then reset mid-stream.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pipe_wen = 1'b1; pipe_rd = 5'd20; pipe_wdata = 32'h2020;
      lu_valid = 1'b1; lu_rd = 5'(21 + i); lu_wdata = 32'h5500 + 32'(i);
      @(posedge clk);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    #1;
    check("mid_full_lu_ready", 64'(lu_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_lu_ready", 64'(lu_ready), 64'd1);
    check("mid_rst_pipe_stall", 64'(pipe_stall), 64'd0);
    check("mid_rst_RegWEn", 64'(RegWEn), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_wdata", 64'(wdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    rs1_addr = 5'd21;
    rs2_addr = 5'd22;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_RegWEn_%0d", c), 64'(RegWEn), 64'd0);
      check($sformatf("post_rst_rs1_busy_%0d", c), 64'(rs1_busy), 64'd0);
      check($sformatf("post_rst_rs2_busy_%0d", c), 64'(rs2_busy), 64'd0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
